// File: rtl/tdc_measure_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tdc_measure_ctrl
// Description : Coarse time-to-digital measurement controller. Synchronises
//               asynchronous start/stop hits, measures the start-to-stop
//               interval in clk_input cycles, times out long intervals and
//               holds the result until a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_measure_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk_input,
  input  logic               reset,
  input  logic               async_start,
  input  logic               async_stop,
  input  logic               arm,
  input  logic               abort,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [COUNT_W-1:0] result_count,
  output logic               result_timeout
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_ARMED   = 2'd1;
  localparam logic [1:0] c_ST_RUNNING = 2'd2;
  localparam logic [1:0] c_ST_HOLD    = 2'd3;

  // Edge flags are suppressed until the chain and the last-level copy hold
  // samples taken after reset, so a level held through reset is not an edge.
  localparam int                    c_SETTLE_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [c_SETTLE_W-1:0] c_SETTLE_DONE = c_SETTLE_W'(SYNC_STAGES + 1);
  localparam logic [COUNT_W-1:0]    c_TIMEOUT     = COUNT_W'(TIMEOUT_CYC);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  w_timed_out;
  logic                  r_busy;
  logic                  r_valid;
  logic                  r_timeout;
  logic                  w_busy_nxt;
  logic                  w_valid_nxt;
  logic                  w_timeout_nxt;
  logic [COUNT_W-1:0]    r_count;
  logic [c_SETTLE_W-1:0] r_settle;
  logic                  w_primed;
  logic [1:0]            w_async_in;
  logic [1:0]            w_edge;
  logic                  w_start_edge;
  logic                  w_stop_edge;

  assign w_async_in   = {async_stop, async_start};
  assign w_start_edge = w_edge[0];
  assign w_stop_edge  = w_edge[1];
  assign w_primed     = (r_settle == c_SETTLE_DONE);

  // Post-reset settle counter gating the edge detectors.
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      r_settle <= '0;
    end else if (r_settle != c_SETTLE_DONE) begin
      r_settle <= r_settle + c_SETTLE_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_last;
      logic                   r_edge;

      // Synchroniser chain, last-level copy and registered rising-edge flag.
      always_ff @(posedge clk_input or posedge reset) begin
        if (reset) begin
          r_sync <= '0;
          r_last <= 1'b0;
          r_edge <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], w_async_in[gi]};
          r_last <= r_sync[SYNC_STAGES-1];
          r_edge <= w_primed & r_sync[SYNC_STAGES-1] & ~r_last;
        end
      end

      assign w_edge[gi] = r_edge;
    end
  endgenerate

  // State register and registered status outputs.
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      r_state   <= c_ST_IDLE;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= w_busy_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Next-state decision; abort overrides everything, stop beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_timed_out = 1'b0;
    if (abort) begin
      w_state_nxt = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (arm) w_state_nxt = c_ST_ARMED;
        end
        c_ST_ARMED: begin
          if (w_start_edge) w_state_nxt = c_ST_RUNNING;
        end
        c_ST_RUNNING: begin
          if (w_stop_edge) begin
            w_state_nxt = c_ST_HOLD;
          end else if (r_count == c_TIMEOUT) begin
            w_state_nxt = c_ST_HOLD;
            w_timed_out = 1'b1;
          end
        end
        c_ST_HOLD: begin
          if (r_valid && result_ready) begin
            w_state_nxt = arm ? c_ST_ARMED : c_ST_IDLE;
          end
        end
        default: w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  // Next values of the status outputs, decoded from the next state.
  always_comb begin
    w_busy_nxt    = (w_state_nxt == c_ST_ARMED) || (w_state_nxt == c_ST_RUNNING);
    w_valid_nxt   = (w_state_nxt == c_ST_HOLD);
    w_timeout_nxt = 1'b0;
    if (w_state_nxt == c_ST_HOLD) begin
      w_timeout_nxt = (r_state == c_ST_HOLD) ? r_timeout : w_timed_out;
    end
  end

  // Interval counter: 1 in the first RUNNING cycle, frozen in HOLD.
  always_ff @(posedge clk_input or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case (w_state_nxt)
        c_ST_RUNNING: r_count <= (r_state == c_ST_RUNNING) ? r_count + COUNT_W'(1) : COUNT_W'(1);
        c_ST_HOLD:    r_count <= r_count;
        default:      r_count <= '0;
      endcase
    end
  end

  assign busy           = r_busy;
  assign result_valid   = r_valid;
  assign result_timeout = r_timeout;
  assign result_count   = r_count;

endmodule
`default_nettype wire

// File: doc/tdc_measure_ctrl.md
TDC_MEASURE_CTRL -- requirements
Module: tdc_measure_ctrl

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth per async input (legal 2..4).
REQ-002 The block SHALL have parameter COUNT_W, default 16, giving the coarse counter and result width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1000, giving the RUNNING timeout in clk_input cycles (legal 1..2^COUNT_W-1).
REQ-004 The block SHALL have port clk_input  input  1  sole clock.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port async_start  input  1  asynchronous start hit.
REQ-007 The block SHALL have port async_stop  input  1  asynchronous stop hit.
REQ-008 The block SHALL have port arm  input  1  synchronous single-cycle request to arm a measurement.
REQ-009 The block SHALL have port abort  input  1  synchronous cancel.
REQ-010 The block SHALL have port busy  output  1  high in ARMED or RUNNING.
REQ-011 The block SHALL have port result_valid  output  1  result available.
REQ-012 The block SHALL have port result_ready  input  1  consumer accepts result.
REQ-013 The block SHALL have port result_count  output  COUNT_W  coarse interval in cycles.
REQ-014 The block SHALL have port result_timeout  output  1  result produced by timeout, not stop.

Function
REQ-015 Each async input SHALL pass through a SYNC_STAGES flop chain and then one edge-detect flop; a rising edge SHALL be flagged exactly SYNC_STAGES+1 cycles after the input is sampled high.
REQ-016 The FSM SHALL have states IDLE, ARMED, RUNNING and HOLD.
REQ-017 IDLE: arm=1 -> ARMED; start/stop edges ignored.
REQ-018 ARMED: start edge -> RUNNING; stop edges ignored; arm ignored.
REQ-019 A start edge and a stop edge flagged in the same ARMED cycle SHALL cause RUNNING with the stop discarded.
REQ-020 RUNNING: if start edge flagged at cycle t and stop edge at t+n, result_count SHALL equal n (n>=1); further start edges ignored.
REQ-021 RUNNING: if no stop edge by t+TIMEOUT_CYC, then -> HOLD with result_count=TIMEOUT_CYC and result_timeout=1; a stop edge flagged in that same cycle SHALL take priority (result_timeout=0).
REQ-022 The counter SHALL never wrap; it saturates by timeout before reaching 2^COUNT_W-1.
REQ-023 HOLD: result_valid=1, with result_count and result_timeout stable until handshake.
REQ-024 In HOLD, result_valid & result_ready SHALL go to IDLE, or to ARMED if arm=1 in the same cycle.
REQ-025 abort=1 SHALL return to IDLE from any state on the next edge and clear result_valid; abort SHALL win over all other inputs.
REQ-026 busy, result_valid and result_timeout SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-027 Reset SHALL asynchronously clear all synchronizer and edge flops to 0, state to IDLE, counter to 0, busy=0, result_valid=0, result_count=0 and result_timeout=0.
REQ-028 Reset asserted mid-RUNNING or mid-HOLD SHALL discard the measurement; after release the block SHALL behave as out of fresh power-up, and an input held high through reset SHALL not produce an edge.

Verification
REQ-029 The bench SHALL cover: arm; async_start high at cycle 10; async_stop high at cycle 47 -> result_valid=1, result_count=37, result_timeout=0, busy=0.
REQ-030 The bench SHALL cover: TIMEOUT_CYC=20; arm; start; no stop -> result_count=20, result_timeout=1.
REQ-031 The bench SHALL cover: stop before start in ARMED -> ignored; the later start/stop pair measured correctly.
REQ-032 The bench SHALL cover: result_ready held 0 for 15 cycles -> outputs stable; ready=1 with arm=1 -> ARMED the next cycle, busy=1.
REQ-033 The bench SHALL cover: abort during RUNNING -> IDLE, busy=0, no result_valid.
REQ-034 The bench SHALL cover: reset pulse during RUNNING with async_start held high -> all outputs 0; after release and arm, no spurious start edge.
